serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/sum width in bits; legal range 2..32.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand set presented.
REQ-005 in_ready  output  1  controller can accept operands.
REQ-006 num1, num2  input  WIDTH  addend operands.
REQ-007 cin  input  1  initial carry into bit 0.
REQ-008 sa_a, sa_b, sa_cin  output  1  bit-serial adder slice inputs.
REQ-009 sa_s, sa_cout  input  1  bit-serial adder slice outputs, combinational from sa_a/sa_b/sa_cin.
REQ-010 abort  input  1  synchronous cancel of an operation in progress.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 sum  output  WIDTH  assembled sum.
REQ-014 cout  output  1  final carry out of bit WIDTH-1.

Function
REQ-015 FSM states IDLE, SHIFT, DONE shall be implemented; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 IDLE: on in_valid=1 at rising edge, latch num1/num2 into operand shift registers, carry register <= cin, bit counter <= 0, go to SHIFT.
REQ-017 SHIFT: sa_a/sa_b = LSB of operand registers, sa_cin = carry register (combinational).
REQ-018 SHIFT each edge: operand registers shift right one, sa_s shifts into sum register MSB (sum register shifts right), carry <= sa_cout, counter +1.
REQ-019 SHIFT with counter = WIDTH-1 at edge: perform REQ-018 step, go to DONE; out_valid rises exactly WIDTH cycles after the accepting edge.
REQ-020 Outside SHIFT, sa_a, sa_b, sa_cin shall be 0.
REQ-021 DONE: sum and cout held stable while out_valid=1 and out_ready=0; on out_ready=1 at edge go to IDLE; no new operands accepted in the same edge.
REQ-022 abort=1 at edge in SHIFT: go to IDLE, counter <= 0; sum/cout hold previous completed values; out_valid not asserted.
REQ-023 abort in IDLE or DONE shall be ignored; abort and in_valid together in IDLE: operands accepted.
REQ-024 in_valid while busy shall be ignored (not queued); num1/num2/cin changes after acceptance have no effect.
REQ-025 Result arithmetic: {cout,sum} = num1 + num2 + cin modulo 2^(WIDTH+1).

Reset
REQ-026 reset low: state IDLE, counter 0, operand/sum/carry registers 0, sum=0, cout=0, out_valid=0, in_ready=1 after release, sa_* = 0.
REQ-027 reset asserted mid-SHIFT or in DONE: operation and result discarded immediately, asynchronously.
REQ-028 First accept possible on first rising edge with reset high.

Configuration
REQ-029 Macro SERIAL_ADD_SUB_EN: when defined, input port sub (1 bit) exists and is latched at acceptance.
REQ-030 With SERIAL_ADD_SUB_EN and sub latched 1: sa_b = inverted operand-2 LSB, carry initialised to 1 (cin ignored); result = num1 - num2 mod 2^WIDTH, cout = 1 when num1 >= num2 (no borrow).
REQ-031 Without SERIAL_ADD_SUB_EN: no sub port, add-only behaviour per REQ-025; cycle timing identical in both builds.

Verification
REQ-032 num1=0x2D, num2=0x7A, cin=0 -> out_valid 8 cycles after accept, sum=0xA7, cout=0.
REQ-033 num1=0xC8, num2=0x64, cin=0 -> sum=0x2C, cout=1; num1=0xFF, num2=0x00, cin=1 -> sum=0x00, cout=1.
REQ-034 out_ready held 0 for 5 cycles in DONE -> sum/cout/out_valid stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-035 abort at 4th SHIFT cycle -> IDLE next edge, out_valid never asserted, sum retains prior result; following op 0x01+0x01 -> 0x02.
REQ-036 reset low at 3rd SHIFT cycle -> all outputs 0 immediately; post-release op 0x2D+0x7A completes correctly.
REQ-037 SERIAL_ADD_SUB_EN build: sub=1, num1=0x0A, num2=0x03 -> sum=0x07, cout=1; num1=0x03, num2=0x0A -> sum=0xF9, cout=0.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial add controller: drives an external 1-bit adder slice LSB-first. Optional subtract mode under SERIAL_ADD_SUB_EN.
// Latency: out_valid rises WIDTH cycles after the accepting edge. One operation is in flight at a time.
// Backpressure: in_ready only in IDLE. The result is held in DONE until out_ready. abort cancels SHIFT.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             sa_a,
    output logic             sa_b,
    output logic             sa_cin,
    input  logic             sa_s,
    input  logic             sa_cout,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] opa, opb;
    logic [WIDTH-2:0] acc;
    logic [WIDTH-1:0] acc_n;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             sub_q;
    logic             sub_in;
    logic             last, accept, step;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    assign last   = (cnt == CW'(WIDTH - 1));
    assign accept = (state == IDLE) && in_valid;
    assign step   = (state == SHIFT) && !abort;
    // The final slice bit becomes the MSB of the completed sum.
    assign acc_n  = {sa_s, acc};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        sa_a      = 1'b0;
        sa_b      = 1'b0;
        sa_cin    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = SHIFT;
            end
            SHIFT: begin
                sa_a   = opa[0];
                sa_b   = opb[0] ^ sub_q;
                sa_cin = carry;
                if (abort)     state_d = IDLE;
                else if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // sum/cout are updated only on completion, so an abort leaves the previous result visible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sub_q <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            opa   <= num1;
            opb   <= num2;
            carry <= sub_in | cin;
            cnt   <= '0;
            sub_q <= sub_in;
        end else if (state == SHIFT && abort) begin
            cnt <= '0;
        end else if (step) begin
            opa   <= opa >> 1;
            opb   <= opb >> 1;
            acc   <= acc_n[WIDTH-1:1];
            carry <= sa_cout;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum  <= acc_n;
                cout <= sa_cout;
            end
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: directed operations against a transaction-level model and literal expectations.
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] num1 = '0, num2 = '0;
    logic         cin = 1'b0;
    logic         sub_r = 1'b0;
    logic         sa_a, sa_b, sa_cin, sa_s, sa_cout;
    logic         abort = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         chk_on = 1'b0;

    int errors = 0;
    int checks = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .num1(num1), .num2(num2), .cin(cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub(sub_r),
`endif
        .sa_a(sa_a), .sa_b(sa_b), .sa_cin(sa_cin),
        .sa_s(sa_s), .sa_cout(sa_cout),
        .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
    );

    // One-bit full adder slice.
    assign sa_s    = sa_a ^ sa_b ^ sa_cin;
    assign sa_cout = (sa_a & sa_b) | (sa_a & sa_cin) | (sa_b & sa_cin);

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W:0] model_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic c, input logic s);
        int tot;
        logic [W-1:0] d;
        if (s) begin
            d = a - b;
            return {(a >= b), d};
        end
        tot = {24'b0, a} + {24'b0, b} + {31'b0, c};
        return tot[W:0];
    endfunction

    // Carry entering bit k = overflow of the low k bits of the (possibly inverted) operands.
    function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic c, input logic s, input int k);
        logic [W-1:0] bb;
        int mk, ec, tot;
        bb  = s ? ~b : b;
        ec  = (s || c) ? 1 : 0;
        mk  = (1 << k) - 1;
        tot = ({24'b0, a} & mk) + ({24'b0, bb} & mk) + ec;
        return tot[k];
    endfunction

    // Transaction model: an accepted operation is busy for W cycles, then its result is presented.
    int           m_cd = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_a = '0, m_b = '0, m_sum = '0;
    logic         m_cin = 1'b0, m_sub = 1'b0, m_cout = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cd <= 0; m_done <= 1'b0; m_a <= '0; m_b <= '0;
            m_cin <= 1'b0; m_sub <= 1'b0; m_sum <= '0; m_cout <= 1'b0;
        end else if (m_cd != 0) begin
            if (abort) begin
                m_cd <= 0;
            end else begin
                m_cd <= m_cd - 1;
                if (m_cd == 1) begin
                    m_done <= 1'b1;
                    {m_cout, m_sum} <= model_result(m_a, m_b, m_cin, m_sub);
                end
            end
        end else if (m_done) begin
            if (out_ready) m_done <= 1'b0;
        end else if (in_valid) begin
            m_a <= num1; m_b <= num2; m_cin <= cin; m_sub <= sub_r; m_cd <= W;
        end
    end

    always @(negedge clk) begin : compare
        int k;
        if (reset && chk_on) begin
            chk("m_in_ready", in_ready, (m_cd == 0 && !m_done));
            chk("m_out_valid", out_valid, m_done);
            chk("m_sum", sum, m_sum);
            chk("m_cout", cout, m_cout);
            if (m_cd != 0) begin
                k = W - m_cd;
                chk("m_sa_a", sa_a, m_a[k]);
                chk("m_sa_b", sa_b, m_b[k] ^ m_sub);
                chk("m_sa_cin", sa_cin, carry_into(m_a, m_b, m_cin, m_sub, k));
            end else begin
                chk("m_sa_idle", {sa_a, sa_b, sa_cin}, 3'b000);
            end
        end
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic [W-1:0] es, input logic ec, input logic ab, input int hold);
        int n;
        @(posedge clk); #1;
        num1 = a; num2 = b; cin = c; in_valid = 1'b1; abort = ab;
        @(posedge clk); #1;
        in_valid = 1'b0; abort = 1'b0;
        num1 = W'($urandom); num2 = W'($urandom); cin = 1'($urandom);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, 8);
        chk("op_sum", sum, es);
        chk("op_cout", cout, ec);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; abort = 1'b1;
            @(posedge clk); #1;
            chk("hold_sum", sum, es);
            chk("hold_cout", cout, ec);
            chk("hold_vld", out_valid, 1);
            chk("hold_rdy", in_ready, 0);
        end
        out_ready = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0; abort = 1'b0;
        chk("release_rdy", in_ready, 1);
        chk("release_vld", out_valid, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic seen;
        #2 reset = 1'b0;
        #1;
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_vld", out_valid, 0);
        chk("rst_sa", {sa_a, sa_b, sa_cin}, 3'b000);
        @(posedge clk); #1 reset = 1'b1;
        #1 chk("rst_rdy", in_ready, 1);
        chk_on = 1'b1;

        do_op(8'h2D, 8'h7A, 1'b0, 8'hA7, 1'b0, 1'b0, 0);
        do_op(8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0, 0);
        do_op(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 0);
        do_op(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b0, 5);
        do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1);
        do_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 0);
        do_op(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b0, 0);

        // Abort in the 4th SHIFT cycle.
        @(posedge clk); #1;
        num1 = 8'h55; num2 = 8'h11; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("abort_idle", in_ready, 1);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_vld", seen, 0);
        chk("abort_sum_kept", sum, 8'h01);
        chk("abort_cout_kept", cout, 1);
        do_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 0);

        // Reset during the 3rd SHIFT cycle.
        @(posedge clk); #1;
        num1 = 8'h2D; num2 = 8'h7A; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        #1;
        chk("arst_sum", sum, 0);
        chk("arst_cout", cout, 0);
        chk("arst_vld", out_valid, 0);
        chk("arst_sa", {sa_a, sa_b, sa_cin}, 3'b000);
        @(posedge clk); #1 reset = 1'b1;
        do_op(8'h2D, 8'h7A, 1'b0, 8'hA7, 1'b0, 1'b0, 0);

`ifdef SERIAL_ADD_SUB_EN
        sub_r = 1'b1;
        do_op(8'h0A, 8'h03, 1'b0, 8'h07, 1'b1, 1'b0, 0);
        do_op(8'h03, 8'h0A, 1'b1, 8'hF9, 1'b0, 1'b0, 0);
        do_op(8'h42, 8'h42, 1'b0, 8'h00, 1'b1, 1'b0, 2);
        sub_r = 1'b0;
        do_op(8'h0A, 8'h03, 1'b0, 8'h0D, 1'b0, 1'b0, 0);
`endif

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
